fp_norm_scheduler: RTL
======================

# fp_norm_scheduler

Round-robin scheduler that shares one floating-point normalization unit (leading-one detect, mantissa left-shift, exponent adjust) among `N_REQ` Maxnet neuron requesters. It accepts requests through per-requester valid/ready handshakes and issues one request per cycle to the shared combinational normalizer. The result is registered and returned with the requester ID on a single valid/ready response port. It sits between the Maxnet neuron update stages and the normalization datapath.

## Interface
- `N_REQ`, default 4: number of requesters, 2..16.
- `ID_W`, default `$clog2(N_REQ)`: requester ID width.
- `clk`, in, 1: clock.
- `rst`, in, 1: synchronous, active-high reset.
- `req_valid`, in, `N_REQ`: request valid, one bit per requester.
- `req_ready`, out, `N_REQ`: request accepted this cycle; at most one bit is high (one-hot or zero).
- `req_exp`, in, `N_REQ*8`: packed exponents; requester i occupies `[8i+7:8i]`.
- `req_mant`, in, `N_REQ*23`: packed unnormalized mantissas, no hidden bit stored; requester i occupies `[23i+22:23i]`.
- `rsp_valid`, out, 1: response register holds a result.
- `rsp_ready`, in, 1: consumer accepts the response.
- `rsp_id`, out, `ID_W`: index of the requester that produced the result.
- `rsp_exp`, out, 8: normalized exponent.
- `rsp_mant`, out, 23: normalized mantissa; the leading one is shifted out as the implicit bit.
- `rsp_zero`, out, 1: input mantissa was zero.
- `rsp_uflow`, out, 1: exponent underflowed.
- `ops_count`, out, 16: number of accepted requests; wraps modulo 2^16.

## Operation
- **Normalize function.** Let p be the index of the highest set bit of `mant`, and s = 23 − p (range 1..23).
  - Nominal result: `mant_out = (mant << s)[22:0]`, `exp_out = exp − s`.
  - `mant == 0`: `exp_out = 0`, `mant_out = 0`, zero = 1, uflow = 0.
  - `exp < s`: `exp_out = 0`, `mant_out = 0`, uflow = 1.
  - The subtraction uses a 9-bit borrow check; there is no wrap-around.
- **Slot free.** `slot_free = !rsp_valid || rsp_ready`.
- **Grant.** When `slot_free` is high, the grant goes to the first i with `req_valid[i]`, searching from `ptr` upward and wrapping modulo `N_REQ`.
  - `req_ready[g] = 1` only for the granted index g. `req_ready` depends combinationally on `req_valid`.
  - When `slot_free` is low, all `req_ready` bits are 0.
- **Pointer.** `ptr` has width `ID_W` and is 0 after reset.
  - On accept: `ptr ← (g + 1) mod N_REQ`.
  - Without an accept, `ptr` holds.
  - A requester with valid held is served within `N_REQ` accepts (no starvation).
- **Response register.**
  - Accept: load `{g, exp_out, mant_out, zero, uflow}` and set `rsp_valid`.
  - `rsp_ready` high with no new accept: clear `rsp_valid`.
  - Consume and accept in the same cycle: the new result replaces the old one and `rsp_valid` stays 1.
  - While `rsp_valid && !rsp_ready`, all `rsp_*` outputs hold stable.
- **Requester obligation.** A requester keeps valid and its data stable until its `req_ready` is seen. The scheduler does not re-check this.
- **Counter.** `ops_count` increments by 1 on each accept.
- **Reset.** All outputs are 0: `rsp_valid`, `rsp_id`, `rsp_exp`, `rsp_mant`, `rsp_zero`, `rsp_uflow`, `ops_count`, and `req_ready` (forced 0 while `rst`). `ptr` is 0.
  - Reset mid-transaction discards any pending response. No accept occurs in a cycle where `rst` is high.

## Timing
- Latency is 1 cycle: a request accepted at edge t has its response visible after edge t (`rsp_valid` = 1 in cycle t+1).
- Throughput is 1 request per cycle when `rsp_ready` is held high.
- The critical path is the grant priority mux, then the 23-bit leading-one detector, then the barrel shifter, then the response register. There are no multicycle paths.
- With `rsp_ready` held low, at most one request is accepted; after that `req_ready` stays all-zero until the response is consumed.

## Structure
- **Shared package `fp_pkg`:**
  - `EXP_W = 8`, `MANT_W = 23`.
  - typedef `fp_norm_t {exp, mant, zero, uflow}`.
  - function `lead_one_idx`.
- **Sub-module `fp_normalize`:** purely combinational, implementing exp/mant in and `fp_norm_t` out. It is instantiated once, and the scheduler feeds it through the grant mux.
- **Scheduler body:** round-robin grant, `ptr`, response register, and counter.

## Test plan
- Single request: requester 2, `exp=100`, `mant=0x600000` → next cycle `rsp_valid=1`, `rsp_id=2`, `rsp_exp=99`, `rsp_mant=0x400000`, `ops_count=1`.
- All four requesters valid from reset with `rsp_ready=1` → grants in the order 0, 1, 2, 3, one per cycle. `rsp_id` sequence is 0, 1, 2, 3. Afterwards `ptr=0` and `ops_count=4`.
- Backpressure: `rsp_ready=0` while requesters 1 and 3 are valid → only 1 is accepted and the response holds for 5 cycles. Raise `rsp_ready` → 3 is accepted in the same cycle the response for 1 is consumed. `rsp_valid` stays 1.
- Edge values:
  - `mant=0` → `rsp_zero=1`, exp 0, mant 0.
  - `exp=100`, `mant=0x000001` → exp 77, mant 0.
  - `exp=5`, `mant=0x000010` (s=19) → `rsp_uflow=1`, exp 0, mant 0.
- Fairness: requester 0 continuously valid and requester 1 toggling valid → requester 1 is served within 2 accepts of asserting.
- Reset while `rsp_valid=1` and `ops_count=0xFFFF` wraps to 0 beforehand → after `rst`, `rsp_valid=0` and all outputs are 0. The first subsequent grant goes to requester 0.

Source files
------------

// File: rtl/fp_pkg.sv
// Shared floating-point normalization types and helpers.
package fp_pkg;

  localparam int EXP_W  = 8;
  localparam int MANT_W = 23;

  typedef struct packed {
    logic [EXP_W-1:0]  exp;
    logic [MANT_W-1:0] mant;
    logic              zero;
    logic              uflow;
  } fp_norm_t;

  // Index of the most significant set bit; 0 when the mantissa is all zero.
  function automatic logic [4:0] lead_one_idx(input logic [MANT_W-1:0] m);
    logic [4:0] idx;
    idx = '0;
    for (int i = 0; i < MANT_W; i++) begin
      if (m[i]) idx = 5'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/fp_normalize.sv
// Combinational normalizer: shifts the leading one out as the implicit bit
// and lowers the exponent to match, flushing to zero on underflow.
module fp_normalize
  import fp_pkg::*;
(
  input  logic [EXP_W-1:0]  exp_in,
  input  logic [MANT_W-1:0] mant_in,
  output fp_norm_t          norm_out
);

  logic [4:0]        lead_idx;
  logic [4:0]        shift_amt;
  logic [EXP_W:0]    exp_diff;
  logic [MANT_W-1:0] mant_shifted;

  always_comb begin
    lead_idx     = lead_one_idx(mant_in);
    shift_amt    = 5'(MANT_W) - lead_idx;
    // Bit EXP_W of the widened difference is the borrow out.
    exp_diff     = {1'b0, exp_in} - {4'b0000, shift_amt};
    mant_shifted = mant_in << shift_amt;
    norm_out     = '0;
    if (mant_in == '0) begin
      norm_out.zero = 1'b1;
    end else if (exp_diff[EXP_W]) begin
      norm_out.uflow = 1'b1;
    end else begin
      norm_out.exp  = exp_diff[EXP_W-1:0];
      norm_out.mant = mant_shifted;
    end
  end

endmodule

// File: rtl/fp_norm_scheduler.sv
// Round-robin arbiter sharing one normalizer among N_REQ requesters, with a
// single registered response slot and an accepted-request counter.
module fp_norm_scheduler
  import fp_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          req_valid,
  output logic [N_REQ-1:0]          req_ready,
  input  logic [N_REQ*EXP_W-1:0]    req_exp,
  input  logic [N_REQ*MANT_W-1:0]   req_mant,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [ID_W-1:0]           rsp_id,
  output logic [EXP_W-1:0]          rsp_exp,
  output logic [MANT_W-1:0]         rsp_mant,
  output logic                      rsp_zero,
  output logic                      rsp_uflow,
  output logic [15:0]               ops_count
);

  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0]   rsp_id_q, rsp_id_d;
  fp_norm_t          rsp_data_q, rsp_data_d;
  logic [15:0]       ops_count_q, ops_count_d;

  logic [ID_W-1:0]   grant_idx;
  logic              grant_found;
  logic              slot_free;
  logic              accept;
  int                cand;
  logic [EXP_W-1:0]  sel_exp;
  logic [MANT_W-1:0] sel_mant;
  fp_norm_t          norm_res;

  // First valid requester at or after ptr, wrapping modulo N_REQ.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = 0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = (int'(ptr_q) + k) % N_REQ;
      if (!grant_found && req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = ID_W'(cand);
      end
    end
  end

  assign slot_free = !rsp_valid_q || rsp_ready;
  assign accept    = slot_free && grant_found && !rst;
  assign sel_exp   = req_exp[grant_idx*EXP_W +: EXP_W];
  assign sel_mant  = req_mant[grant_idx*MANT_W +: MANT_W];

  fp_normalize u_norm (
    .exp_in   (sel_exp),
    .mant_in  (sel_mant),
    .norm_out (norm_res)
  );

  always_comb begin
    req_ready   = '0;
    ptr_d       = ptr_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_data_d  = rsp_data_q;
    ops_count_d = ops_count_q;
    if (accept) begin
      req_ready[grant_idx] = 1'b1;
      ptr_d       = (grant_idx == ID_W'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
      rsp_valid_d = 1'b1;
      rsp_id_d    = grant_idx;
      rsp_data_d  = norm_res;
      ops_count_d = ops_count_q + 16'd1;
    end else if (rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
      ops_count_q <= '0;
    end else begin
      ptr_q       <= ptr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
      ops_count_q <= ops_count_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_exp   = rsp_data_q.exp;
  assign rsp_mant  = rsp_data_q.mant;
  assign rsp_zero  = rsp_data_q.zero;
  assign rsp_uflow = rsp_data_q.uflow;
  assign ops_count = ops_count_q;

endmodule
